// File: rtl/ethertype_steer.sv
// EtherType steering controller: strips the 14-byte MAC header, selects IPv4/ARP
// for the downstream split, forwards payload beats and keeps saturating frame counters.
module ethertype_steer #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         ethertype_out,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         busy,
  output logic [15:0]  ip_count,
  output logic [15:0]  arp_count,
  output logic [15:0]  drop_count
);

  localparam int HDR_BEATS = 112 / N;
  localparam int BPB       = 8 / N;
  localparam int BW        = $clog2(HDR_BEATS + 1);

  localparam logic [BW-1:0] LAST_BEAT   = BW'(HDR_BEATS - 1);
  localparam logic [BW-1:0] BYTE12_BEAT = BW'(13 * BPB - 1);

  localparam logic [15:0] ET_IPV4 = 16'h0800;
  localparam logic [15:0] ET_ARP  = 16'h0806;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_beat;
  logic [7:0]      r_byte;
  logic [7:0]      r_et_hi;
  logic            r_ethertype;
  logic            r_axiov;
  logic [N-1:0]    r_axiod;
  logic            r_busy;
  logic [15:0]     r_ip_count;
  logic [15:0]     r_arp_count;
  logic [15:0]     r_drop_count;

  logic [7:0]      w_byte_nxt;
  logic [15:0]     w_ethertype;
  logic            w_is_ip;
  logic            w_is_arp;
  logic            w_shift;
  logic            w_classify;
  logic            w_fwd;
  logic            w_inc_ip;
  logic            w_inc_arp;
  logic            w_inc_drop;

  // Bytes arrive LSB first, so each new beat enters at the top of the shifter.
  if (N == 8) begin : g_full_byte
    assign w_byte_nxt = axiid;
  end else begin : g_part_byte
    assign w_byte_nxt = {axiid, r_byte[7:N]};
  end

  assign w_ethertype = {r_et_hi, w_byte_nxt};
  assign w_is_ip     = (w_ethertype == ET_IPV4);
  assign w_is_arp    = (w_ethertype == ET_ARP);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (axiiv) w_state_nxt = S_HEADER;
      S_HEADER: begin
        if (!axiiv)                  w_state_nxt = S_IDLE;
        else if (r_beat == LAST_BEAT) w_state_nxt = (w_is_ip || w_is_arp) ? S_PAYLOAD : S_DROP;
      end
      S_PAYLOAD: if (!axiiv) w_state_nxt = S_IDLE;
      S_DROP:    if (!axiiv) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state control decode.
  always_comb begin
    w_shift    = 1'b0;
    w_classify = 1'b0;
    w_fwd      = 1'b0;
    w_inc_ip   = 1'b0;
    w_inc_arp  = 1'b0;
    w_inc_drop = 1'b0;
    case (r_state)
      S_IDLE:    w_shift = axiiv;
      S_HEADER: begin
        w_shift    = axiiv;
        w_classify = axiiv && (r_beat == LAST_BEAT);
        w_inc_drop = !axiiv;
      end
      S_PAYLOAD: begin
        w_fwd     = axiiv;
        w_inc_ip  = !axiiv && !r_ethertype;
        w_inc_arp = !axiiv &&  r_ethertype;
      end
      S_DROP:    w_inc_drop = !axiiv;
      default:   ;
    endcase
  end

  // Datapath and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat       <= '0;
      r_byte       <= '0;
      r_et_hi      <= '0;
      r_ethertype  <= 1'b0;
      r_axiov      <= 1'b0;
      r_axiod      <= '0;
      r_busy       <= 1'b0;
      r_ip_count   <= '0;
      r_arp_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE);
      r_axiov <= w_fwd;
      if (w_fwd) r_axiod <= axiid;

      // The IDLE beat that opens a frame is beat 0, so the counter leaves it at 1.
      if (w_shift) begin
        r_byte <= w_byte_nxt;
        r_beat <= (r_state == S_IDLE) ? BW'(1) : r_beat + 1'b1;
      end else begin
        r_beat <= '0;
      end

      if (r_state == S_HEADER && axiiv && r_beat == BYTE12_BEAT) r_et_hi <= w_byte_nxt;
      if (w_classify && (w_is_ip || w_is_arp)) r_ethertype <= w_is_arp;

      if (w_inc_ip   && r_ip_count   != 16'hFFFF) r_ip_count   <= r_ip_count   + 16'd1;
      if (w_inc_arp  && r_arp_count  != 16'hFFFF) r_arp_count  <= r_arp_count  + 16'd1;
      if (w_inc_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign ethertype_out = r_ethertype;
  assign axiov         = r_axiov;
  assign axiod         = r_axiod;
  assign busy          = r_busy;
  assign ip_count      = r_ip_count;
  assign arp_count     = r_arp_count;
  assign drop_count    = r_drop_count;

endmodule
